gray_counter_ud: RTL

GRAY_COUNTER_UD -- requirements
Module: gray_counter_ud

---
 rtl/gray_counter_ud.sv | 97 +++++++++
 1 files changed

// File: rtl/gray_counter_ud.sv
// Up/down Gray-code counter with a binary state register, wrap/saturate terminal behaviour and terminal-count flag.
// Optional Gray-sequence checker driving err is compiled in only when GRAY_COUNTER_UD_CHK_EN is defined.
module gray_counter_ud #(
  parameter int DATA_WIDTH = 4,
  parameter bit WRAP       = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_bin,
  output logic [DATA_WIDTH-1:0] out,
  output logic [DATA_WIDTH-1:0] bin,
  output logic                  tc,
  output logic                  err
);

  localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;
  localparam logic [DATA_WIDTH-1:0] ZERO     = '0;
  localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);

  logic [DATA_WIDTH-1:0] bin_q, bin_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  at_top;
  logic                  at_bottom;
  logic                  tc_int;

  always_comb begin
    at_top    = (bin_q == ALL_ONES);
    at_bottom = (bin_q == ZERO);
    tc_int    = ~reset & en & ~load & ((up & at_top) | (~up & at_bottom));
  end

  // Binary modular arithmetic wraps on its own; saturation only needs to block the terminal step.
  always_comb begin
    bin_d = bin_q;
    if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      if (tc_int && !WRAP) begin
        bin_d = bin_q;
      end else if (up) begin
        bin_d = bin_q + ONE;
      end else begin
        bin_d = bin_q - ONE;
      end
    end
    out_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q <= ZERO;
      out_q <= ZERO;
    end else begin
      bin_q <= bin_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;
  assign bin = bin_q;
  assign tc  = tc_int;

`ifdef GRAY_COUNTER_UD_CHK_EN
  logic [DATA_WIDTH-1:0] prev_out_q;
  logic [DATA_WIDTH-1:0] diff;
  logic                  exempt_q;
  logic                  multi_bit;
  logic                  err_q, err_d;

  // exempt_q marks an out_q value produced by load or reset, whose jump from the previous value is legal.
  always_comb begin
    diff      = out_q ^ prev_out_q;
    multi_bit = ((diff & (diff - ONE)) != ZERO);
    err_d     = err_q | (multi_bit & ~exempt_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_out_q <= ZERO;
      exempt_q   <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      prev_out_q <= out_q;
      exempt_q   <= load;
      err_q      <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
